// File: rtl/hack_control_fsm_pkg.sv
// Shared Hack-16 definitions: sequencer state encoding, instruction field
// positions and small decode helpers used by the control FSM and CPU variants.
package hack_pkg;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_DECODE = 2'd2;
   localparam logic [1:0] S_EXEC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = S_IDLE,
      ST_FETCH  = S_FETCH,
      ST_DECODE = S_DECODE,
      ST_EXEC   = S_EXEC
   } state_t;

   localparam int CI_BIT  = 15;
   localparam int A_BIT   = 12;
   localparam int DEST_A  = 5;
   localparam int DEST_D  = 4;
   localparam int DEST_M  = 3;
   localparam int JMP_HI  = 2;
   localparam int JMP_LO  = 0;

   function automatic logic is_cinstr(input logic [15:0] word);
      return word[CI_BIT];
   endfunction

endpackage

// File: rtl/hack_control_fsm_if.sv
// Control bus between the Hack-16 sequencer (master) and the datapath/ROM side
// (slave): instruction word, ALU flags, register enables and status.
interface hack_control_fsm_if #(
   parameter int CNT_W = 16
);
   logic             run;
   logic [15:0]      instr_in;
   logic             alu_zr;
   logic             alu_ng;
   logic [15:0]      ir;
   logic             a_load;
   logic             a_sel;
   logic             am_sel;
   logic             d_load;
   logic             m_write;
   logic             pc_load;
   logic             pc_inc;
   logic             busy;
   logic [CNT_W-1:0] retired;

   modport master (
      input  run, instr_in, alu_zr, alu_ng,
      output ir, a_load, a_sel, am_sel, d_load, m_write, pc_load, pc_inc, busy, retired
   );

   modport slave (
      output run, instr_in, alu_zr, alu_ng,
      input  ir, a_load, a_sel, am_sel, d_load, m_write, pc_load, pc_inc, busy, retired
   );
endinterface

// File: rtl/hack_jump_cond.sv
// Hack jump-condition evaluator: decides whether a C-instruction's jump field
// is satisfied by the current ALU zero/negative flags.
module hack_jump_cond (
   input  logic [2:0] jump,
   input  logic       zr,
   input  logic       ng,
   output logic       taken
);
   assign taken = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~zr & ~ng);
endmodule

// File: rtl/hack_control_fsm.sv
// Multi-cycle Hack-16 sequencer: FETCH latches the ROM word, DECODE lets M and
// the flags settle, EXEC fires the register/memory enables for one cycle.
module hack_control_fsm
   import hack_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   hack_control_fsm_if.master  bus
);

   state_t           state_r;
   logic [15:0]      ir_r;
   logic [CNT_W-1:0] retired_r;
   logic             jmp_s;
   logic             a_load_s;
   logic             a_sel_s;
   logic             d_load_s;
   logic             m_write_s;
   logic             pc_load_s;
   logic             pc_inc_s;

   hack_jump_cond u_jump (
      .jump  (ir_r[JMP_HI:JMP_LO]),
      .zr    (bus.alu_zr),
      .ng    (bus.alu_ng),
      .taken (jmp_s)
   );

   // Sequencer state, instruction register and retired-instruction counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         ir_r      <= 16'h0000;
         retired_r <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.run) state_r <= ST_FETCH;
               else         state_r <= ST_IDLE;
            end
            ST_FETCH: begin
               ir_r    <= bus.instr_in;
               state_r <= ST_DECODE;
            end
            ST_DECODE: begin
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
               state_r   <= bus.run ? ST_FETCH : ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // EXEC-only enable decode; flags are used as sampled now, so a jump that
   // also writes A still targets the old A.
   always_comb begin
      a_load_s  = 1'b0;
      a_sel_s   = 1'b0;
      d_load_s  = 1'b0;
      m_write_s = 1'b0;
      pc_load_s = 1'b0;
      pc_inc_s  = 1'b0;
      if (state_r == ST_EXEC) begin
         if (is_cinstr(ir_r)) begin
            a_load_s  = ir_r[DEST_A];
            a_sel_s   = 1'b1;
            d_load_s  = ir_r[DEST_D];
            m_write_s = ir_r[DEST_M];
            pc_load_s = jmp_s;
            pc_inc_s  = ~jmp_s;
         end else begin
            a_load_s  = 1'b1;
            a_sel_s   = 1'b0;
            pc_inc_s  = 1'b1;
         end
      end else begin
         pc_inc_s  = 1'b0;
      end
   end

   assign bus.ir      = ir_r;
   assign bus.retired = retired_r;
   assign bus.am_sel  = ir_r[A_BIT];
   assign bus.busy    = (state_r != ST_IDLE);
   assign bus.a_load  = a_load_s;
   assign bus.a_sel   = a_sel_s;
   assign bus.d_load  = d_load_s;
   assign bus.m_write = m_write_s;
   assign bus.pc_load = pc_load_s;
   assign bus.pc_inc  = pc_inc_s;

endmodule
